// File: rtl/pcie_sym_pkg.sv
// PCIe Gen1 symbol constants and the scrambler LFSR byte-step helper.
// The LFSR is a 16-bit Galois register for x^16+x^5+x^4+x^3+1.
package pcie_sym_pkg;

  localparam logic [7:0]  K_COM = 8'hBC;
  localparam logic [7:0]  K_SKP = 8'h1C;
  localparam logic [7:0]  K_STP = 8'hFB;
  localparam logic [7:0]  K_SDP = 8'h5C;
  localparam logic [7:0]  K_END = 8'hFD;
  localparam logic [7:0]  K_EDB = 8'hFE;
  localparam logic [7:0]  K_IDL = 8'h7C;
  localparam logic [7:0]  K_FTS = 8'h3C;

  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  localparam logic [15:0] LFSR_POLY = 16'h0039;

  typedef struct packed {
    logic [7:0]  k8;
    logic [15:0] l_next;
  } lfsr_step_t;

  // Eight serial shifts unrolled into one combinational step; k8 is LSB-first.
  function automatic lfsr_step_t lfsr_step8(input logic [15:0] l,
                                            input logic [15:0] poly = LFSR_POLY);
    lfsr_step_t r;
    logic [15:0] s;
    s    = l;
    r.k8 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      r.k8[k] = s[15];
      s       = {s[14:0], 1'b0} ^ (s[15] ? poly : 16'h0000);
    end
    r.l_next = s;
    return r;
  endfunction

endpackage

// File: rtl/scrambler_lane.sv
// One scrambler lane: owns its LFSR and the registered output byte and K-flag.
// COM re-seeds, SKP freezes the LFSR, every other valid symbol advances it by 8 bits.
module scrambler_lane
  import pcie_sym_pkg::*;
#(
  parameter logic [15:0] SEED_P = LFSR_SEED,
  parameter logic [15:0] POLY_P = LFSR_POLY,
  parameter logic [7:0]  COM_P  = K_COM,
  parameter logic [7:0]  SKP_P  = K_SKP
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       valid_i,
  input  logic       scr_dis_i,
  input  logic [7:0] byte_i,
  input  logic       dk_i,
  output logic [7:0] byte_o,
  output logic       dk_o
);

  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  byte_q, byte_d;
  logic        dk_q, dk_d;
  lfsr_step_t  step_s;

  // Next-state for the LFSR and output registers; idle beats hold everything.
  always_comb begin
    step_s = lfsr_step8(lfsr_q, POLY_P);
    lfsr_d = lfsr_q;
    byte_d = byte_q;
    dk_d   = dk_q;
    if (valid_i) begin
      dk_d = dk_i;
      if (dk_i) begin
        byte_d = byte_i;
        if (byte_i == COM_P) begin
          lfsr_d = SEED_P;
        end else if (byte_i == SKP_P) begin
          lfsr_d = lfsr_q;
        end else begin
          lfsr_d = step_s.l_next;
        end
      end else begin
        // Bypass only skips the XOR; the keystream position still moves on.
        lfsr_d = step_s.l_next;
        if (scr_dis_i) begin
          byte_d = byte_i;
        end else begin
          byte_d = byte_i ^ step_s.k8;
        end
      end
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // Lane state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= SEED_P;
      byte_q <= 8'h00;
      dk_q   <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      byte_q <= byte_d;
      dk_q   <= dk_d;
    end
  end

  assign byte_o = byte_q;
  assign dk_o   = dk_q;

endmodule

// File: rtl/lane_scrambler.sv
// Four-lane PCIe Gen1 data scrambler placed after byte striping.
// Lanes are independent; one clock of latency from input beat to scrambled output.
module lane_scrambler
  import pcie_sym_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED,
  parameter logic [15:0] POLY = LFSR_POLY,
  parameter logic [7:0]  COM  = K_COM,
  parameter logic [7:0]  SKP  = K_SKP
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VALID,
  input  logic       SCR_DIS,
  input  logic [7:0] LANE0,
  input  logic [7:0] LANE1,
  input  logic [7:0] LANE2,
  input  logic [7:0] LANE3,
  input  logic       DK_0,
  input  logic       DK_1,
  input  logic       DK_2,
  input  logic       DK_3,
  output logic [7:0] SLANE0,
  output logic [7:0] SLANE1,
  output logic [7:0] SLANE2,
  output logic [7:0] SLANE3,
  output logic       SDK_0,
  output logic       SDK_1,
  output logic       SDK_2,
  output logic       SDK_3,
  output logic       VALID_OUT
);

  logic valid_out_q;

  scrambler_lane #(.SEED_P(SEED), .POLY_P(POLY), .COM_P(COM), .SKP_P(SKP)) u_lane0 (
    .clk_i(CLK), .reset_i(RESET), .valid_i(VALID), .scr_dis_i(SCR_DIS),
    .byte_i(LANE0), .dk_i(DK_0), .byte_o(SLANE0), .dk_o(SDK_0)
  );

  scrambler_lane #(.SEED_P(SEED), .POLY_P(POLY), .COM_P(COM), .SKP_P(SKP)) u_lane1 (
    .clk_i(CLK), .reset_i(RESET), .valid_i(VALID), .scr_dis_i(SCR_DIS),
    .byte_i(LANE1), .dk_i(DK_1), .byte_o(SLANE1), .dk_o(SDK_1)
  );

  scrambler_lane #(.SEED_P(SEED), .POLY_P(POLY), .COM_P(COM), .SKP_P(SKP)) u_lane2 (
    .clk_i(CLK), .reset_i(RESET), .valid_i(VALID), .scr_dis_i(SCR_DIS),
    .byte_i(LANE2), .dk_i(DK_2), .byte_o(SLANE2), .dk_o(SDK_2)
  );

  scrambler_lane #(.SEED_P(SEED), .POLY_P(POLY), .COM_P(COM), .SKP_P(SKP)) u_lane3 (
    .clk_i(CLK), .reset_i(RESET), .valid_i(VALID), .scr_dis_i(SCR_DIS),
    .byte_i(LANE3), .dk_i(DK_3), .byte_o(SLANE3), .dk_o(SDK_3)
  );

  // Output valid follows the input valid by one clock.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= VALID;
    end
  end

  assign VALID_OUT = valid_out_q;

endmodule

// File: tb/tb_lane_scrambler.sv
// Self-checking bench for lane_scrambler: directed vector table plus randomized
// traffic checked against an arithmetic keystream model.
module tb_lane_scrambler;

  logic       CLK = 1'b0;
  logic       RESET, VALID, SCR_DIS;
  logic [7:0] LANE0, LANE1, LANE2, LANE3;
  logic       DK_0, DK_1, DK_2, DK_3;
  logic [7:0] SLANE0, SLANE1, SLANE2, SLANE3;
  logic       SDK_0, SDK_1, SDK_2, SDK_3;
  logic       VALID_OUT;

  int n_cmp = 0;
  int n_bad = 0;

  lane_scrambler dut (
    .CLK(CLK), .RESET(RESET), .VALID(VALID), .SCR_DIS(SCR_DIS),
    .LANE0(LANE0), .LANE1(LANE1), .LANE2(LANE2), .LANE3(LANE3),
    .DK_0(DK_0), .DK_1(DK_1), .DK_2(DK_2), .DK_3(DK_3),
    .SLANE0(SLANE0), .SLANE1(SLANE1), .SLANE2(SLANE2), .SLANE3(SLANE3),
    .SDK_0(SDK_0), .SDK_1(SDK_1), .SDK_2(SDK_2), .SDK_3(SDK_3),
    .VALID_OUT(VALID_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        rst;
    logic        valid;
    logic        scr;
    logic [31:0] lanes;   // {lane3, lane2, lane1, lane0}
    logic [3:0]  dk;
    logic [31:0] exp_lanes;
    logic [3:0]  exp_dk;
    logic        exp_v;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: one keystream register per lane plus the visible outputs.
  int          m_lfsr[4];
  logic [7:0]  m_out[4];
  logic        m_dk[4];
  logic        m_v;

  function automatic logic [36:0] actual();
    return {SLANE3, SLANE2, SLANE1, SLANE0, SDK_3, SDK_2, SDK_1, SDK_0, VALID_OUT};
  endfunction

  function automatic logic [36:0] model_out();
    return {m_out[3], m_out[2], m_out[1], m_out[0], m_dk[3], m_dk[2], m_dk[1], m_dk[0], m_v};
  endfunction

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Multiply by x modulo x^16+x^5+x^4+x^3+1, eight times; the keystream bit is the
  // coefficient that overflows out of x^15 on each multiply.
  function automatic void keystream(input int l_in, output int k8, output int l_out);
    int l;
    l  = l_in;
    k8 = 0;
    for (int b = 0; b < 8; b++) begin
      if ((l & 32'h0000_8000) != 0) k8 = k8 | (1 << b);
      l = l * 2;
      if ((l & 32'h0001_0000) != 0) l = l ^ 32'h0001_0039;
    end
    l_out = l;
  endfunction

  task automatic model_beat(input logic rst, input logic valid, input logic scr,
                            input logic [31:0] lanes, input logic [3:0] dk);
    int k8, nl;
    logic [7:0] b;
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        m_lfsr[n] = 32'h0000_FFFF; m_out[n] = 8'h00; m_dk[n] = 1'b0;
      end
      m_v = 1'b0;
    end else begin
      m_v = valid;
      if (valid) begin
        for (int n = 0; n < 4; n++) begin
          b = lanes[8*n +: 8];
          keystream(m_lfsr[n], k8, nl);
          m_dk[n] = dk[n];
          if (dk[n] && b == 8'hBC) begin
            m_out[n] = b; m_lfsr[n] = 32'h0000_FFFF;
          end else if (dk[n] && b == 8'h1C) begin
            m_out[n] = b;
          end else if (dk[n]) begin
            m_out[n] = b; m_lfsr[n] = nl;
          end else begin
            m_out[n] = scr ? b : (b ^ k8[7:0]); m_lfsr[n] = nl;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic rst, input logic valid, input logic scr,
                       input logic [31:0] lanes, input logic [3:0] dk);
    RESET = rst; VALID = valid; SCR_DIS = scr;
    {LANE3, LANE2, LANE1, LANE0} = lanes;
    {DK_3, DK_2, DK_1, DK_0} = dk;
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input string nm, input logic r, input logic v, input logic s,
                     input logic [31:0] l, input logic [3:0] d,
                     input logic [31:0] el, input logic [3:0] ed, input logic ev);
    vec_t x;
    x.name = nm; x.rst = r; x.valid = v; x.scr = s; x.lanes = l; x.dk = d;
    x.exp_lanes = el; x.exp_dk = ed; x.exp_v = ev;
    vecs.push_back(x);
  endtask

  initial begin
    logic [31:0] rl;
    logic [3:0]  rd;
    logic        rv, rs, rr;
    logic [7:0]  kb;

    // Directed vectors: each row is one beat and the outputs expected after that edge.
    add("com_all",     0, 1, 0, 32'hBCBCBCBC, 4'hF, 32'hBCBCBCBC, 4'hF, 1);
    add("d0_ff",       0, 1, 0, 32'h00000000, 4'h0, 32'hFFFFFFFF, 4'h0, 1);
    add("d1_17",       0, 1, 0, 32'h00000000, 4'h0, 32'h17171717, 4'h0, 1);
    add("d2_c0",       0, 1, 0, 32'h00000000, 4'h0, 32'hC0C0C0C0, 4'h0, 1);
    add("d3_14",       0, 1, 0, 32'h00000000, 4'h0, 32'h14141414, 4'h0, 1);
    add("skp_com",     0, 1, 0, 32'hBCBCBCBC, 4'hF, 32'hBCBCBCBC, 4'hF, 1);
    add("skp_d0",      0, 1, 0, 32'h00000000, 4'h0, 32'hFFFFFFFF, 4'h0, 1);
    add("skp_lane0",   0, 1, 0, 32'h0000001C, 4'h1, 32'h1717171C, 4'h1, 1);
    add("skp_after",   0, 1, 0, 32'h00000000, 4'h0, 32'hC0C0C017, 4'h0, 1);
    add("gap_com",     0, 1, 0, 32'hBCBCBCBC, 4'hF, 32'hBCBCBCBC, 4'hF, 1);
    add("gap_idle0",   0, 0, 0, 32'h12345678, 4'hA, 32'hBCBCBCBC, 4'hF, 0);
    add("gap_idle1",   0, 0, 1, 32'hBC1C00FF, 4'h5, 32'hBCBCBCBC, 4'hF, 0);
    add("gap_idle2",   0, 0, 0, 32'hBCBCBCBC, 4'hF, 32'hBCBCBCBC, 4'hF, 0);
    add("gap_resume0", 0, 1, 0, 32'h00000000, 4'h0, 32'hFFFFFFFF, 4'h0, 1);
    add("gap_resume1", 0, 1, 0, 32'h00000000, 4'h0, 32'h17171717, 4'h0, 1);
    add("bcdata_com",  0, 1, 0, 32'hBCBCBCBC, 4'hF, 32'hBCBCBCBC, 4'hF, 1);
    add("bcdata",      0, 1, 0, 32'hBCBCBCBC, 4'h0, 32'h43434343, 4'h0, 1);
    add("bcdata_next", 0, 1, 0, 32'h00000000, 4'h0, 32'h17171717, 4'h0, 1);
    add("stp_com",     0, 1, 0, 32'hBCBCBCBC, 4'hF, 32'hBCBCBCBC, 4'hF, 1);
    add("stp_k",       0, 1, 0, 32'hFBFBFBFB, 4'hF, 32'hFBFBFBFB, 4'hF, 1);
    add("stp_next",    0, 1, 0, 32'h00000000, 4'h0, 32'h17171717, 4'h0, 1);
    add("dis_com",     0, 1, 0, 32'hBCBCBCBC, 4'hF, 32'hBCBCBCBC, 4'hF, 1);
    add("dis_d0",      0, 1, 0, 32'h00000000, 4'h0, 32'hFFFFFFFF, 4'h0, 1);
    add("dis_raw",     0, 1, 1, 32'h5A00A500, 4'h0, 32'h5A00A500, 4'h0, 1);
    add("dis_after",   0, 1, 0, 32'h00000000, 4'h0, 32'hC0C0C0C0, 4'h0, 1);
    add("mid_reset",   1, 1, 0, 32'h00000000, 4'h0, 32'h00000000, 4'h0, 0);
    add("post_rst0",   0, 1, 0, 32'h00000000, 4'h0, 32'hFFFFFFFF, 4'h0, 1);
    add("post_rst1",   0, 1, 0, 32'h00000000, 4'h0, 32'h17171717, 4'h0, 1);

    // Reset for two clocks, then check cleared outputs and seeded LFSRs.
    drive(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 4'hF);
    drive(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 4'hF);
    chk("reset_outputs", actual(), 37'h0);
    chk("reset_lfsr", {5'h0, dut.u_lane0.lfsr_q, dut.u_lane3.lfsr_q},
        {5'h0, 16'hFFFF, 16'hFFFF});
    chk("reset_lfsr_mid", {5'h0, dut.u_lane1.lfsr_q, dut.u_lane2.lfsr_q},
        {5'h0, 16'hFFFF, 16'hFFFF});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].scr, vecs[i].lanes, vecs[i].dk);
      chk(vecs[i].name, actual(), {vecs[i].exp_lanes, vecs[i].exp_dk, vecs[i].exp_v});
    end

    // Randomized traffic: re-sync model with a reset, then compare every beat.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
    model_beat(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
    chk("rand_reset", actual(), model_out());
    for (int t = 0; t < 600; t++) begin
      rr = ($urandom_range(99) < 2);
      rv = ($urandom_range(99) < 80);
      rs = ($urandom_range(99) < 10);
      rl = $urandom;
      rd = 4'h0;
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(3) == 0) begin
          rd[n] = 1'b1;
          case ($urandom_range(3))
            0: kb = 8'hBC;
            1: kb = 8'h1C;
            2: kb = 8'hFB;
            default: kb = rl[8*n +: 8];
          endcase
          rl[8*n +: 8] = kb;
        end
      end
      drive(rr, rv, rs, rl, rd);
      model_beat(rr, rv, rs, rl, rd);
      chk($sformatf("rand_%0d", t), actual(), model_out());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
